// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C transaction arbiter.
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/i2c_txn_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from i_last+1 with wrap
// and returns the first set request as a one-hot vector and an index.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    logic [IDX_W-1:0] w_pos;

    // Walk candidates from lowest to highest priority so the nearest one after i_last wins
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_pos = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_pos]) begin
                o_onehot        = '0;
                o_onehot[w_pos] = 1'b1;
                o_idx           = w_pos;
                o_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C write master between NUM_REQ clients.
// Latches the winner's address/data, launches one write, waits for the master
// to finish or time out, and returns done/err to the granted client.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int TMO_W       = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic                          m_start,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic [I2C_DATA_W-1:0]         m_data,
    input  logic                          m_done,
    input  logic                          m_nack,
    output logic                          m_abort,
    output logic                          busy
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    arb_state_e            r_state;
    arb_state_e            w_next;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    w_win;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      r_last;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_valid;
    logic [I2C_ADDR_W-1:0] r_addr;
    logic [I2C_ADDR_W-1:0] w_addr;
    logic [I2C_DATA_W-1:0] r_data;
    logic [I2C_DATA_W-1:0] w_data;
    logic [TMO_W-1:0]      r_cnt;
    logic                  r_nack;
    logic                  r_tmo;
    logic                  w_expire;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_onehot (w_win),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    // Route the winning client's address and data slices
    always_comb begin
        w_addr = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win[i]) begin
                w_addr = req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
                w_data = req_data[i*I2C_DATA_W +: I2C_DATA_W];
            end
        end
    end

    assign w_expire = (r_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a master completion beats a same-cycle expiry
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:     if (w_valid) w_next = LAUNCH;
            LAUNCH:   w_next = WAIT;
            WAIT:     if (m_done || w_expire) w_next = COMPLETE;
            COMPLETE: w_next = IDLE;
        endcase
    end

    // Grant, latched request, timeout counter and completion status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gnt  <= '0;
            r_idx  <= '0;
            r_last <= IDX_W'(NUM_REQ - 1);
            r_addr <= '0;
            r_data <= '0;
            r_cnt  <= '0;
            r_nack <= 1'b0;
            r_tmo  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt  <= w_win;
                        r_idx  <= w_idx;
                        r_addr <= w_addr;
                        r_data <= w_data;
                    end
                end
                LAUNCH: begin
                    r_cnt  <= '0;
                    r_nack <= 1'b0;
                    r_tmo  <= 1'b0;
                end
                WAIT: begin
                    r_cnt <= r_cnt + TMO_W'(1);
                    if (m_done)        r_nack <= m_nack;
                    else if (w_expire) r_tmo  <= 1'b1;
                end
                COMPLETE: begin
                    r_gnt  <= '0;
                    r_last <= r_idx;
                end
            endcase
        end
    end

    // Per-state outputs; completion pulses go only to the granted client
    always_comb begin
        m_start = (r_state == LAUNCH);
        busy    = (r_state != IDLE);
        done    = '0;
        err     = '0;
        m_abort = 1'b0;
        if (r_state == COMPLETE) begin
            done    = r_gnt;
            err     = (r_nack || r_tmo) ? r_gnt : '0;
            m_abort = r_tmo;
        end
    end

    assign gnt    = r_gnt;
    assign m_addr = r_addr;
    assign m_data = r_data;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: the driver pushes the expected
// transaction before raising req; a monitor checks it at m_start and at done.
module tb_i2c_txn_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int TMO_W       = 5;

    logic                 clk;
    logic                 reset;
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 m_start;
    logic [6:0]           m_addr;
    logic [7:0]           m_data;
    logic                 m_done;
    logic                 m_nack;
    logic                 m_abort;
    logic                 busy;

    i2c_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TMO_W       (TMO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .err      (err),
        .m_start  (m_start),
        .m_addr   (m_addr),
        .m_data   (m_data),
        .m_done   (m_done),
        .m_nack   (m_nack),
        .m_abort  (m_abort),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] gnt;
        logic [6:0] addr;
        logic [7:0] data;
        logic       err;
        logic       abort;
        int         lat;      // cycles from m_start to the done pulse
        bit         no_done;  // transaction is killed by reset, no done expected
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input logic [3:0] g, input logic [6:0] a, input logic [7:0] d,
                              input logic er, input logic ab, input int lat, input bit nd);
        exp_t t;
        t.gnt = g; t.addr = a; t.data = d; t.err = er; t.abort = ab; t.lat = lat; t.no_done = nd;
        q.push_back(t);
    endtask

    // Monitor: invariants each cycle, launch contents at m_start, completion at done
    int cyc = 0;
    int start_cyc = 0;
    int starts_in_txn = 0;
    always @(negedge clk) begin
        if (reset) begin
            starts_in_txn = 0;
        end else begin
            cyc++;
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (m_start) begin
                starts_in_txn++;
                start_cyc = cyc;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_start actual gnt=%b required none", gnt);
                end else begin
                    chk("start_gnt",  32'(gnt),    32'(q[0].gnt));
                    chk("start_addr", 32'(m_addr), 32'(q[0].addr));
                    chk("start_data", 32'(m_data), 32'(q[0].data));
                    chk("start_busy", 32'(busy),   32'd1);
                    if (q[0].no_done) e = q.pop_front();
                end
            end
            if ((|done) || (|err) || m_abort) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual done=%b err=%b abort=%b required none", done, err, m_abort);
                end else begin
                    e = q.pop_front();
                    chk("done",        32'(done),    32'(e.gnt));
                    chk("err",         32'(err),     32'(e.err ? e.gnt : 4'b0000));
                    chk("abort",       32'(m_abort), 32'(e.abort));
                    chk("gnt_at_done", 32'(gnt),     32'(e.gnt));
                    chk("addr_at_done",32'(m_addr),  32'(e.addr));
                    chk("data_at_done",32'(m_data),  32'(e.data));
                    chk("start_count", 32'(starts_in_txn), 32'd1);
                    chk("latency",     32'(cyc - start_cyc), 32'(e.lat));
                end
                starts_in_txn = 0;
            end
        end
    end

    task automatic wait_start();
        int n = 0;
        while (m_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("wait_start", 32'(m_start), 32'd1);
    endtask

    task automatic finish_txn(input int dly, input logic nack, input bit hang, input logic [3:0] req_after);
        int n = 0;
        if (!hang) begin
            repeat (dly) @(negedge clk);
            m_done = 1'b1; m_nack = nack;
            @(negedge clk);
            m_done = 1'b0; m_nack = 1'b0;
        end
        while (!(|done) && n < 64) begin @(negedge clk); n++; end
        chk("wait_done", 32'(|done), 32'd1);
        req = req_after;
    endtask

    task automatic serve(input int dly, input logic nack, input bit hang, input logic [3:0] req_after);
        wait_start();
        finish_txn(dly, nack, hang, req_after);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},     32'(gnt),     32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_m_start"}, 32'(m_start), 32'd0);
        chk({tag, "_m_abort"}, 32'(m_abort), 32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_m_addr"},  32'(m_addr),  32'd0);
        chk({tag, "_m_data"},  32'(m_data),  32'd0);
    endtask

    localparam logic [27:0] ADDRS = {7'h7F, 7'h3C, 7'h50, 7'h20};
    localparam logic [31:0] DATAS = {8'hFF, 8'h5A, 8'hA5, 8'h01};

    initial begin
        reset = 1'b1; req = '0; m_done = 1'b0; m_nack = 1'b0;
        req_addr = ADDRS; req_data = DATAS;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Round robin with all four requesting: order 0,1,2,3,0
        expect_txn(4'b0001, 7'h20, 8'h01, 1'b0, 1'b0, 4, 1'b0);
        expect_txn(4'b0010, 7'h50, 8'hA5, 1'b0, 1'b0, 4, 1'b0);
        expect_txn(4'b0100, 7'h3C, 8'h5A, 1'b0, 1'b0, 4, 1'b0);
        expect_txn(4'b1000, 7'h7F, 8'hFF, 1'b0, 1'b0, 4, 1'b0);
        expect_txn(4'b0001, 7'h20, 8'h01, 1'b0, 1'b0, 4, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve(3, 1'b0, 1'b0, 4'b1111);
        serve(3, 1'b0, 1'b0, 4'b0000);

        // Single request; slice changes after grant must not reach the master
        expect_txn(4'b0010, 7'h50, 8'hA5, 1'b0, 1'b0, 11, 1'b0);
        req = 4'b0010;
        wait_start();
        req_addr[13:7] = 7'h11; req_data[15:8] = 8'h00;
        finish_txn(10, 1'b0, 1'b0, 4'b0000);
        req_addr = ADDRS; req_data = DATAS;

        // Stray master completion while idle is ignored
        @(negedge clk);
        m_done = 1'b1; m_nack = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_nack = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_stray_busy", 32'(busy), 32'd0);
        chk("idle_stray_gnt",  32'(gnt),  32'd0);

        // Nack on requester 2
        expect_txn(4'b0100, 7'h3C, 8'h5A, 1'b1, 1'b0, 8, 1'b0);
        req = 4'b0100;
        serve(7, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        chk("nack_gnt_clear", 32'(gnt), 32'd0);

        // Timeout on requester 0: 16 WAIT cycles, then COMPLETE with abort
        expect_txn(4'b0001, 7'h20, 8'h01, 1'b1, 1'b1, 17, 1'b0);
        req = 4'b0001;
        serve(0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        chk("tmo_idle_busy", 32'(busy), 32'd0);

        // Completion on the expiry cycle: no abort, err follows m_nack
        expect_txn(4'b1000, 7'h7F, 8'hFF, 1'b0, 1'b0, 17, 1'b0);
        req = 4'b1000;
        serve(16, 1'b0, 1'b0, 4'b0000);
        expect_txn(4'b0010, 7'h50, 8'hA5, 1'b1, 1'b0, 17, 1'b0);
        req = 4'b0010;
        serve(16, 1'b1, 1'b0, 4'b0000);

        // Reset while waiting: no done, then pointer restarts at requester 0
        @(negedge clk);
        expect_txn(4'b0001, 7'h20, 8'h01, 1'b0, 1'b0, 0, 1'b1);
        req = 4'b0001;
        wait_start();
        repeat (3) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        reset = 1'b1; req = 4'b1001;
        @(negedge clk);
        check_all_zero("rst_wait");
        expect_txn(4'b0001, 7'h20, 8'h01, 1'b0, 1'b0, 6, 1'b0);
        expect_txn(4'b1000, 7'h7F, 8'hFF, 1'b0, 1'b0, 6, 1'b0);
        reset = 1'b0;
        serve(5, 1'b0, 1'b0, 4'b1000);
        serve(5, 1'b0, 1'b0, 4'b0000);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
